// File: rtl/cell_seq_pkg.sv
// ---------------------------------------------------------------------------
// cell_seq_pkg
// Shared types and default configuration for the cell_seq timestep sequencer.
//   state_e      : sequencer FSM states (IDLE, RUN, DRAIN, FIN)
//   DEF_*        : default parameter values for cell_seq / cell_seq_if
// ---------------------------------------------------------------------------
package cell_seq_pkg;

    localparam int DEF_ADDR     = 12;   // memory_cell address width
    localparam int DEF_WIDTH    = 32;   // data word width
    localparam int DEF_NUM      = 53;   // words per timestep region
    localparam int DEF_TIMESTEP = 1;    // number of timestep regions

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage : cell_seq_pkg

// File: rtl/cell_seq_if.sv
// ---------------------------------------------------------------------------
// cell_seq_if
// Bus bundle between cell_seq and its neighbours (memory_cell + MAC stage).
//   memory_cell port b : mem_addr_b (seq->mem), mem_o_b (mem->seq, 1-cycle reg)
//   memory_cell port a : mem_wr_a, mem_addr_a, mem_i_a (seq->mem write)
//   read stream        : rd_data, rd_valid (seq->MAC), rd_ready (MAC->seq)
//   result stream      : wr_data, wr_valid (downstream->seq)
// rd_ready only exists when CELL_SEQ_STALL_EN is defined.
// Modports: master = cell_seq, slave = memory/downstream side.
// ---------------------------------------------------------------------------
interface cell_seq_if
    import cell_seq_pkg::*;
#(
    parameter int ADDR  = DEF_ADDR,
    parameter int WIDTH = DEF_WIDTH
);

    logic [ADDR-1:0]  mem_addr_b;
    logic [WIDTH-1:0] mem_o_b;
    logic             mem_wr_a;
    logic [ADDR-1:0]  mem_addr_a;
    logic [WIDTH-1:0] mem_i_a;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
`ifdef CELL_SEQ_STALL_EN
    logic             rd_ready;
`endif

    modport master (
        output mem_addr_b, mem_wr_a, mem_addr_a, mem_i_a, rd_data, rd_valid,
`ifdef CELL_SEQ_STALL_EN
        input  rd_ready,
`endif
        input  mem_o_b, wr_data, wr_valid
    );

    modport slave (
        input  mem_addr_b, mem_wr_a, mem_addr_a, mem_i_a, rd_data, rd_valid,
`ifdef CELL_SEQ_STALL_EN
        output rd_ready,
`endif
        output mem_o_b, wr_data, wr_valid
    );

endinterface : cell_seq_if

// File: rtl/cell_seq.sv
// ---------------------------------------------------------------------------
// cell_seq
// Streams one NUM-word timestep region out of memory_cell (port b) to the MAC
// while writing NUM result words into another region (port a).
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   start          : begin a job (sampled in IDLE only)
//   rd_ts / wr_ts  : source / destination timestep region index
//   busy           : job in progress (RUN, DRAIN, FIN)
//   done / err     : one-cycle completion / bad-region pulses
//   bus (master)   : memory ports and read/result streams, see cell_seq_if
// Optional feature: define CELL_SEQ_STALL_EN to add rd_ready back-pressure.
// ---------------------------------------------------------------------------
module cell_seq
    import cell_seq_pkg::*;
#(
    parameter int ADDR     = DEF_ADDR,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM      = DEF_NUM,
    parameter int TIMESTEP = DEF_TIMESTEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] rd_ts,
    input  logic [ADDR-1:0] wr_ts,
    output logic            busy,
    output logic            done,
    output logic            err,
    cell_seq_if.master      bus
);

    localparam int              CW       = $clog2(NUM + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NUM - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(NUM);
    localparam logic [ADDR:0]   TS_LIM   = (ADDR + 1)'(TIMESTEP);
    localparam logic [ADDR-1:0] NUM_A    = ADDR'(NUM);

    // Regions must fit in the address space.
    if (longint'(NUM) * longint'(TIMESTEP) > (longint'(1) << ADDR)) begin : g_bad_cfg
        $error("cell_seq: NUM*TIMESTEP exceeds 2**ADDR");
    end

    state_e          r_state;
    state_e          w_state_nxt;
    logic [ADDR-1:0] r_rd_base;
    logic [ADDR-1:0] r_wr_base;
    logic [ADDR-1:0] r_addr_b;     // last issued read address
    logic [CW-1:0]   r_rd_cnt;
    logic [CW-1:0]   r_wr_cnt;
    logic            r_rd_valid;
    logic            r_err;

    logic            w_ts_ok;
    logic            w_accept;
    logic            w_take;
    logic            w_issue;
    logic            w_wr_en;
    logic            w_rd_fin;
    logic            w_wr_fin;
    logic [ADDR-1:0] w_issue_addr;

    assign w_ts_ok = ({1'b0, rd_ts} < TS_LIM) && ({1'b0, wr_ts} < TS_LIM);

`ifdef CELL_SEQ_STALL_EN
    assign w_take = r_rd_valid && bus.rd_ready;
`else
    assign w_take = r_rd_valid;
`endif

    // A new address goes out only when the presented beat (if any) is taken,
    // so during a stall the memory keeps re-reading the same word.
    assign w_issue      = (r_state == RUN) && (!r_rd_valid || w_take);
    assign w_issue_addr = r_rd_base + ADDR'(r_rd_cnt);

    assign w_wr_en  = bus.wr_valid && ((r_state == RUN) || (r_state == DRAIN))
                      && (r_wr_cnt < CNT_FULL);
    assign w_rd_fin = (r_rd_cnt == CNT_FULL) && (!r_rd_valid || w_take);
    assign w_wr_fin = (r_wr_cnt == CNT_FULL) || (w_wr_en && (r_wr_cnt == CNT_LAST));

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = (r_state != IDLE);
        done        = (r_state == FIN);
        case (r_state)
            IDLE: begin
                if (start && w_ts_ok) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN:     if (w_issue && (r_rd_cnt == CNT_LAST)) w_state_nxt = DRAIN;
            DRAIN:   if (w_rd_fin && w_wr_fin)              w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_base  <= '0;
            r_wr_base  <= '0;
            r_addr_b   <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= (r_state == IDLE) && start && !w_ts_ok;
            // A beat stays valid until taken; each issue produces one beat.
            r_rd_valid <= w_issue || (r_rd_valid && !w_take);
            if (w_accept) begin
                r_rd_base <= rd_ts * NUM_A;
                r_wr_base <= wr_ts * NUM_A;
                r_rd_cnt  <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    r_addr_b <= w_issue_addr;
                end
                if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    assign err            = r_err;
    assign bus.mem_addr_b = w_issue ? w_issue_addr : r_addr_b;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = bus.mem_o_b;
    assign bus.mem_wr_a   = w_wr_en;
    assign bus.mem_addr_a = r_wr_base + ADDR'(r_wr_cnt);
    assign bus.mem_i_a    = bus.wr_data;

endmodule : cell_seq

// File: tb/tb_cell_seq.sv
// ---------------------------------------------------------------------------
// tb_cell_seq
// Directed bench for cell_seq with NUM=4, TIMESTEP=3, ADDR=4 and a
// read-before-write memory_cell model preloaded with mem[i]=i.
// Build with +define+CELL_SEQ_STALL_EN to include the back-pressure test.
// ---------------------------------------------------------------------------
module tb_cell_seq;

    localparam int ADDR     = 4;
    localparam int WIDTH    = 32;
    localparam int NUM      = 4;
    localparam int TIMESTEP = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [ADDR-1:0] rd_ts;
    logic [ADDR-1:0] wr_ts;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic             mem_load;
    logic [WIDTH-1:0] mem [16];

    cell_seq_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

    cell_seq #(
        .ADDR(ADDR), .WIDTH(WIDTH), .NUM(NUM), .TIMESTEP(TIMESTEP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rd_ts (rd_ts),
        .wr_ts (wr_ts),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // memory_cell model: registered read, read-before-write on collision.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= WIDTH'(i);
        end else begin
            if (bus.mem_wr_a) mem[bus.mem_addr_a] <= bus.mem_i_a;
            bus.mem_o_b <= mem[bus.mem_addr_b];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        mem_load     = 1'b1;
        start        = 1'b0;
        rd_ts        = '0;
        wr_ts        = '0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h55;
`ifdef CELL_SEQ_STALL_EN
        bus.rd_ready = 1'b1;
`endif
        cyc();
        mem_load = 1'b0;
        cyc();
        cyc();
        #1;
        checks++;
        if ({busy, done, err, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_a, bus.mem_addr_b} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b rd_valid=%b mem_wr_a=%b addr_a=%0d addr_b=%0d, want all 0",
                     busy, done, err, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_a, bus.mem_addr_b);
        end
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h want 00000000", bus.rd_data);
        end
        rst = 1'b0;
        cyc();
        #1;
        checks++;
        if ({busy, bus.mem_wr_a} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b mem_wr_a=%b, want 0 0", busy, bus.mem_wr_a);
        end
        bus.wr_valid = 1'b0;
    endtask

    // One full job with wr_valid held every cycle (NUM+3 attempts) and a
    // stray start in the middle of RUN; expected timing from job start:
    // C1 issue, C2..C5 beats, C1..C4 writes, C6 done, C7 idle.
    task automatic run_job(input string tag, input logic [ADDR-1:0] rts,
                           input logic [ADDR-1:0] wts,
                           input logic [WIDTH-1:0] dbase,
                           input logic [WIDTH-1:0] wbase);
        logic [ADDR-1:0] rb, wb, eb, ea;
        logic            e_busy, e_done, e_rv, e_wr;
        rb = ADDR'(int'(rts) * NUM);
        wb = ADDR'(int'(wts) * NUM);
        start        = 1'b1;
        rd_ts        = rts;
        wr_ts        = wts;
        bus.wr_valid = 1'b0;
        cyc();
        for (int c = 1; c <= 7; c++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wbase + WIDTH'(c - 1);
            if (c == 3) begin
                start = 1'b1;
                rd_ts = '0;
                wr_ts = '0;
            end else begin
                start = 1'b0;
                rd_ts = rts;
                wr_ts = wts;
            end
            #1;
            e_busy = (c <= 6);
            e_done = (c == 6);
            e_rv   = (c >= 2) && (c <= 5);
            e_wr   = (c <= 4);
            eb     = rb + ADDR'((c < 4) ? c - 1 : 3);
            ea     = wb + ADDR'((c < 5) ? c - 1 : 4);
            checks++;
            if ({busy, done, err, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_b, bus.mem_addr_a}
                !== {e_busy, e_done, 1'b0, e_rv, e_wr, eb, ea}) begin
                errors++;
                $display("FAIL %s_ctrl c%0d: busy=%b done=%b err=%b rv=%b wr=%b ab=%0d aa=%0d, want %b %b 0 %b %b %0d %0d",
                         tag, c, busy, done, err, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_b,
                         bus.mem_addr_a, e_busy, e_done, e_rv, e_wr, eb, ea);
            end
            if (e_rv) begin
                checks++;
                if (bus.rd_data !== dbase + WIDTH'(c - 2)) begin
                    errors++;
                    $display("FAIL %s_rd_data c%0d: got %h want %h",
                             tag, c, bus.rd_data, dbase + WIDTH'(c - 2));
                end
            end
            cyc();
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            checks++;
            if (mem[wb + ADDR'(i)] !== wbase + WIDTH'(i)) begin
                errors++;
                $display("FAIL %s_mem[%0d]: got %h want %h",
                         tag, wb + ADDR'(i), mem[wb + ADDR'(i)], wbase + WIDTH'(i));
            end
        end
        checks++;
        if (mem[wb + 4'd4] !== WIDTH'(wb + 4'd4)) begin
            errors++;
            $display("FAIL %s_dropped_write mem[%0d]: got %h want %h",
                     tag, wb + 4'd4, mem[wb + 4'd4], WIDTH'(wb + 4'd4));
        end
    endtask

    task automatic test_basic();
        run_job("basic", 4'd1, 4'd2, 32'h4, 32'hA0);
    endtask

    task automatic test_err();
        logic [ADDR-1:0] cr [2];
        logic [ADDR-1:0] cw [2];
        cr[0] = 4'd3; cw[0] = 4'd0;
        cr[1] = 4'd0; cw[1] = 4'd3;
        for (int k = 0; k < 2; k++) begin
            start        = 1'b1;
            rd_ts        = cr[k];
            wr_ts        = cw[k];
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hEE;
            #1;
            checks++;
            if ({err, busy, bus.mem_wr_a} !== 3'b000) begin
                errors++;
                $display("FAIL err_same_cycle case%0d: err=%b busy=%b wr=%b, want 0 0 0",
                         k, err, busy, bus.mem_wr_a);
            end
            cyc();
            start = 1'b0;
            #1;
            checks++;
            if ({err, busy, bus.mem_wr_a} !== 3'b100) begin
                errors++;
                $display("FAIL err_pulse case%0d: err=%b busy=%b wr=%b, want 1 0 0",
                         k, err, busy, bus.mem_wr_a);
            end
            cyc();
            #1;
            checks++;
            if ({err, busy, bus.mem_wr_a} !== 3'b000) begin
                errors++;
                $display("FAIL err_end case%0d: err=%b busy=%b wr=%b, want 0 0 0",
                         k, err, busy, bus.mem_wr_a);
            end
            bus.wr_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        start        = 1'b1;
        rd_ts        = 4'd1;
        wr_ts        = 4'd2;
        bus.wr_valid = 1'b0;
        cyc();
        start = 1'b0;
        #1;
        checks++;
        if ({busy, bus.mem_addr_b} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL mid_issue: busy=%b addr_b=%0d, want 1 4", busy, bus.mem_addr_b);
        end
        for (int b = 0; b < 2; b++) begin
            cyc();
            #1;
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'(4 + b)}) begin
                errors++;
                $display("FAIL mid_beat%0d: rv=%b data=%h, want 1 %h",
                         b, bus.rd_valid, bus.rd_data, 32'(4 + b));
            end
        end
        rst = 1'b1;
        cyc();
        #1;
        checks++;
        if ({busy, done, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_a, bus.mem_addr_b} !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b rv=%b wr=%b aa=%0d ab=%0d, want all 0",
                     busy, done, bus.rd_valid, bus.mem_wr_a, bus.mem_addr_a, bus.mem_addr_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL mid_no_done %0d: busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
        run_job("restart", 4'd2, 4'd0, 32'hA0, 32'hB0);
    endtask

`ifdef CELL_SEQ_STALL_EN
    task automatic test_stall();
        logic [WIDTH-1:0] got [$];
        int               done_cnt;
        done_cnt     = 0;
        start        = 1'b1;
        rd_ts        = 4'd1;
        wr_ts        = 4'd2;
        bus.wr_valid = 1'b0;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus.rd_ready = !((c >= 3) && (c <= 5));
            bus.wr_valid = (c <= 4);
            bus.wr_data  = 32'hC0 + WIDTH'(c - 1);
            #1;
            if ((c >= 3) && (c <= 5)) begin
                checks++;
                if ({bus.rd_valid, bus.rd_data, bus.mem_addr_b} !== {1'b1, 32'h5, 4'd5}) begin
                    errors++;
                    $display("FAIL stall_hold c%0d: rv=%b data=%h ab=%0d, want 1 5 5",
                             c, bus.rd_valid, bus.rd_data, bus.mem_addr_b);
                end
            end
            if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
            if (done) done_cnt++;
            cyc();
        end
        bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b0;
        checks++;
        if (got.size() != NUM) begin
            errors++;
            $display("FAIL stall_beat_count: got %0d want %0d", got.size(), NUM);
        end else begin
            for (int i = 0; i < NUM; i++) begin
                checks++;
                if (got[i] !== WIDTH'(4 + i)) begin
                    errors++;
                    $display("FAIL stall_order beat%0d: got %h want %h", i, got[i], WIDTH'(4 + i));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: got %0d pulses want 1", done_cnt);
        end
        for (int i = 0; i < NUM; i++) begin
            checks++;
            if (mem[8 + i] !== 32'hC0 + WIDTH'(i)) begin
                errors++;
                $display("FAIL stall_mem[%0d]: got %h want %h", 8 + i, mem[8 + i], 32'hC0 + WIDTH'(i));
            end
        end
    endtask
`endif

    // Reads 0..3 (B0..B3) while writing D0..D3 to the same addresses in the
    // same cycles: reads return the old words.
    task automatic test_rbw();
        run_job("rbw", 4'd0, 4'd0, 32'hB0, 32'hD0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_reset_mid();
`ifdef CELL_SEQ_STALL_EN
        test_stall();
`endif
        test_rbw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cell_seq

// File: doc/cell_seq.md
CELL_SEQ -- requirements
Module: cell_seq

Interface
REQ-001 Parameter ADDR, 12, address width of memory_cell ports.
REQ-002 Parameter WIDTH, 32, data word width.
REQ-003 Parameter NUM, 53, words per timestep region.
REQ-004 Parameter TIMESTEP, 1, number of timestep regions.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Ports: start in 1 (begin job); rd_ts in ADDR (source region); wr_ts in ADDR (destination region).
REQ-008 Ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (one-cycle pulse).
REQ-009 Ports: mem_addr_b out ADDR; mem_o_b in WIDTH (memory_cell port-b read, 1-cycle registered latency).
REQ-010 Ports: mem_wr_a out 1; mem_addr_a out ADDR; mem_i_a out WIDTH (memory_cell port-a write).
REQ-011 Ports: rd_data out WIDTH; rd_valid out 1: read stream to the downstream MAC.
REQ-012 Ports: wr_data in WIDTH; wr_valid in 1: result stream from the downstream stage.

Function
REQ-013 FSM states IDLE, RUN, DRAIN, FIN; reset state IDLE.
REQ-014 IDLE: start with rd_ts<TIMESTEP and wr_ts<TIMESTEP latches rd_base=rd_ts*NUM, wr_base=wr_ts*NUM, clears counters, goes to RUN next cycle.
REQ-015 IDLE: start with either ts >= TIMESTEP pulses err next cycle, stays IDLE, no memory write.
REQ-016 start outside IDLE is ignored; busy=1 in RUN, DRAIN, FIN.
REQ-017 RUN: mem_addr_b=rd_base+rd_cnt; rd_cnt advances 0..NUM-1 by one per advancing cycle.
REQ-018 rd_valid is asserted the cycle after each address issue, with rd_data=mem_o_b combinationally; exactly NUM rd_valid beats per job, in address order.
REQ-019 After rd_cnt=NUM-1 issues, go to DRAIN; DRAIN lasts until the final rd_valid beat is consumed.
REQ-020 Writes in RUN/DRAIN: wr_valid with wr_cnt<NUM drives mem_wr_a=1, mem_addr_a=wr_base+wr_cnt, mem_i_a=wr_data same cycle; wr_cnt increments.
REQ-021 wr_valid with wr_cnt=NUM, or in IDLE/FIN, is dropped: mem_wr_a=0.
REQ-022 Reads and writes proceed concurrently and independently; same-address read and write in one cycle returns old data (memory_cell read-before-write).
REQ-023 Leave DRAIN to FIN when final read beat done and wr_cnt=NUM; FIN pulses done one cycle, then IDLE.
REQ-024 mem_addr_a idles at wr_base+wr_cnt (saturated), mem_addr_b at last issued address; address arithmetic modulo 2^ADDR.
REQ-025 NUM*TIMESTEP shall not exceed 2^ADDR; elaboration-time check.

Reset
REQ-026 rst returns to IDLE from any state, mid-job included, aborting without done.
REQ-027 Reset values: busy, done, err, rd_valid, mem_wr_a = 0; mem_addr_a, mem_addr_b, counters, bases = 0.
REQ-028 rd_data during reset follows mem_o_b; qualified only by rd_valid.

Configuration
REQ-029 Macro CELL_SEQ_STALL_EN: when defined, input rd_ready (1 bit) exists; beat transfers only on rd_valid&&rd_ready.
REQ-030 With stall: while rd_valid&&!rd_ready, mem_addr_b and rd_cnt hold, so rd_data stays stable.
REQ-031 Without macro: no rd_ready port; every rd_valid beat is consumed; read phase is exactly NUM cycles.

Structure
REQ-032 Package cell_seq_pkg holds state enum (IDLE, RUN, DRAIN, FIN) and default parameter constants.
REQ-033 No sub-module; memory_cell is instantiated beside cell_seq by the parent, not inside.

Verification
REQ-034 NUM=4, TIMESTEP=3, memory preloaded with index value; start rd_ts=1, wr_ts=2 -> mem_addr_b 4,5,6,7; rd_data 4,5,6,7 on consecutive cycles; done after four writes.
REQ-035 Same job, wr_valid every cycle with 0xA0..0xA3 -> addresses 8..11 written 0xA0..0xA3; fifth wr_valid dropped.
REQ-036 start rd_ts=3 (TIMESTEP=3) -> err pulse one cycle, busy stays 0, mem_wr_a never 1.
REQ-037 rst asserted in RUN after two beats -> next cycle IDLE, rd_valid=0, no done; new start runs clean job from counter 0.
REQ-038 CELL_SEQ_STALL_EN, rd_ready low cycles 2-4 -> rd_data holds value 5, beat count still 4, order 4,5,6,7.
REQ-039 rd_ts=wr_ts=0 with simultaneous read/write of address 0 -> rd_data returns old value, memory then holds new value.
